tinyqv_mem_sequencer: RTL



---
 rtl/tinyqv_memseq_pkg.sv | 16 +
 rtl/tinyqv_mem_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tinyqv_memseq_pkg.sv
// Shared constants for the TinyQV multi-word load/store sequencer.
// Holds the FSM state encoding and transfer sizing used by tinyqv_mem_sequencer.
package tinyqv_memseq_pkg;

  typedef enum logic [1:0] {
    MEMSEQ_IDLE = 2'd0,
    MEMSEQ_REQ  = 2'd1,
    MEMSEQ_WAIT = 2'd2
  } memseq_state_t;

  localparam int WORD_BYTES = 4;
  localparam int MAX_XFERS  = 8;
  // additional_ops counts extra transfers, so it never needs to hold MAX_XFERS itself
  localparam int XFER_IDX_BITS = $clog2(MAX_XFERS);

endpackage

// File: rtl/tinyqv_mem_sequencer.sv
// Breaks one decoded load/store into 1-8 word transactions to the memory controller.
// Optional transfer counter output enabled by defining TINYQV_MEMSEQ_XFER_COUNT_EN.
module tinyqv_mem_sequencer
  import tinyqv_memseq_pkg::*;
#(
  parameter int REG_ADDR_BITS = 4,
  parameter int ADDR_BITS     = 28
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  output logic                     start_ready,
  input  logic                     is_store,
  input  logic [ADDR_BITS-1:0]     base_addr,
  input  logic [REG_ADDR_BITS-1:0] first_reg,
  input  logic [2:0]               additional_ops,
  input  logic                     increment_reg,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [ADDR_BITS-1:0]     req_addr,
  output logic                     req_is_store,
  output logic [REG_ADDR_BITS-1:0] req_reg,
  input  logic                     resp_valid,
  input  logic [31:0]              resp_data,
  output logic                     rd_wen,
  output logic [REG_ADDR_BITS-1:0] rd_addr,
  output logic [31:0]              rd_data,
  output logic                     done,
`ifdef TINYQV_MEMSEQ_XFER_COUNT_EN
  output logic [15:0]              xfer_count,
`endif
  output logic                     misaligned
);

  memseq_state_t              state_q, state_d;
  logic [ADDR_BITS-1:0]       addr_q;
  logic [REG_ADDR_BITS-1:0]   reg_q;
  logic                       is_store_q;
  logic                       inc_q;
  logic [XFER_IDX_BITS-1:0]   remaining_q;
  logic                       req_valid_q;

  logic load_en;
  logic step_en;
  logic xfer_done;
  logic done_c;
  logic rd_wen_c;
  logic misaligned_c;

  always_comb begin
    state_d      = state_q;
    load_en      = 1'b0;
    step_en      = 1'b0;
    xfer_done    = 1'b0;
    done_c       = 1'b0;
    rd_wen_c     = 1'b0;
    misaligned_c = 1'b0;
    case (state_q)
      MEMSEQ_IDLE: begin
        if (start) begin
          if (base_addr[1:0] == 2'b00) begin
            load_en = 1'b1;
            state_d = MEMSEQ_REQ;
          end else begin
            misaligned_c = 1'b1;
          end
        end
      end
      MEMSEQ_REQ: begin
        if (req_ready) begin
          // Stores complete on acceptance; loads complete when data returns
          if (is_store_q) begin
            xfer_done = 1'b1;
            if (remaining_q == '0) begin
              done_c  = 1'b1;
              state_d = MEMSEQ_IDLE;
            end else begin
              step_en = 1'b1;
            end
          end else begin
            state_d = MEMSEQ_WAIT;
          end
        end
      end
      MEMSEQ_WAIT: begin
        if (resp_valid) begin
          rd_wen_c  = 1'b1;
          xfer_done = 1'b1;
          if (remaining_q == '0) begin
            done_c  = 1'b1;
            state_d = MEMSEQ_IDLE;
          end else begin
            step_en = 1'b1;
            state_d = MEMSEQ_REQ;
          end
        end
      end
      default: state_d = MEMSEQ_IDLE;
    endcase
  end

  // Pulses are suppressed while reset is held so a sequence aborted mid-flight never reports
  assign start_ready  = (state_q == MEMSEQ_IDLE);
  assign rd_wen       = rd_wen_c & rstn;
  assign done         = done_c & rstn;
  assign misaligned   = misaligned_c & rstn;
  assign rd_addr      = reg_q;
  assign rd_data      = resp_data;
  assign req_valid    = req_valid_q;
  assign req_addr     = addr_q;
  assign req_reg      = reg_q;
  assign req_is_store = is_store_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= MEMSEQ_IDLE;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      reg_q       <= '0;
      is_store_q  <= 1'b0;
      inc_q       <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= (state_d == MEMSEQ_REQ);
      if (load_en) begin
        addr_q      <= base_addr;
        reg_q       <= first_reg;
        is_store_q  <= is_store;
        inc_q       <= increment_reg;
        remaining_q <= additional_ops;
      end else if (step_en) begin
        // Both address and register index wrap naturally at their widths
        addr_q      <= addr_q + ADDR_BITS'(WORD_BYTES);
        reg_q       <= reg_q + REG_ADDR_BITS'(inc_q);
        remaining_q <= remaining_q - 1'b1;
      end
    end
  end

`ifdef TINYQV_MEMSEQ_XFER_COUNT_EN
  logic [15:0] xfer_count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      xfer_count_q <= '0;
    end else if (xfer_done) begin
      xfer_count_q <= xfer_count_q + 16'd1;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule
